lfsr_stream_checker: RTL
========================

Name: lfsr_stream_checker

Overview:
- Receive-side companion to the fpga_LFSR benchmark: consumes the parallel LFSR state word driven out of the FPGA fabric each cycle.
- Predicts the next state with the same polynomial, self-synchronises to the stream, and reports lock, mismatches and a saturating error count.
- Instantiated beside the formal-verification top in the random testbench; also synthesisable for on-fabric BIST.

Parameters:
- WIDTH, 24, LFSR state width; sets data_in and prediction width.
- TAP_MASK, 24'hE10000, feedback tap bits (x^24+x^23+x^22+x^17+1); fb = XOR-reduce(state & TAP_MASK).
- LOCK_COUNT, 4, consecutive correct predictions required to declare lock (1..15).
- UNLOCK_ERRORS, 3, consecutive mismatches while locked that drop lock (1..15).
- CNT_W, 16, width of err_count and word_count.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- reset, input, 1, asynchronous active-high reset.
- data_valid, input, 1, data_in holds a new LFSR word this cycle.
- data_in, input, WIDTH, observed LFSR state (bit 0 = newest shifted-in bit).
- locked, output, 1, checker is synchronised to the stream.
- err_pulse, output, 1, one-cycle pulse per mismatching word while locked.
- err_count, output, CNT_W, total mismatches while locked; saturates at all-ones.
- word_count, output, CNT_W, valid words checked while locked; saturates.
- zero_word, output, 1, sticky: an all-zero word (LFSR lockup) was received.

Behaviour:
- Next-state function: next(s) = {s[WIDTH-2:0], ^(s & TAP_MASK)}.
- Reset (async assert, sync-safe deassert): state=SEARCH, predict=0, run=0, miss=0, all outputs 0.
- All outputs registered; each output reflects the valid word sampled on the previous edge. Latency is 1 cycle.
- data_valid=0: no state, counter or prediction change; err_pulse=0.
- SEARCH:
  - On a valid nonzero word, predict <= next(data_in), run <= 0, go to VERIFY.
  - All-zero words are never accepted as a seed; state stays SEARCH.
- VERIFY:
  - Valid word == predict: run+1, predict <= next(data_in). If run+1 == LOCK_COUNT, go to LOCKED with locked=1 and miss=0.
  - Mismatch: reseed with predict <= next(data_in), run <= 0, stay in VERIFY.
  - No err_pulse and no counting in this state.
- LOCKED:
  - Every valid word: word_count+1 (saturating); predict <= next(predict) (flywheel, so a corrupt word does not corrupt the prediction).
  - Match: miss <= 0.
  - Mismatch: err_pulse=1, err_count+1 (saturating), miss+1. If miss+1 == UNLOCK_ERRORS, go to SEARCH with locked=0 on the same edge. err_pulse still fires for that final word.
- zero_word: set on any valid all-zero data_in in any state; cleared only by reset. An all-zero word in LOCKED is also a mismatch, because the prediction is never zero.
- Saturation: counters hold at 2^CNT_W-1, with no wrap. err_pulse still fires when err_count is saturated.
- Reset mid-operation: immediately returns to SEARCH and clears counters, including zero_word.

Test Plan:
- Reset, then valid seed 24'h800000 followed by the correct sequence 000001, 000002, 000004, 000008 -> locked rises 1 cycle after the 4th matching word; err_count=0.
- While locked, inject a single corrupted word (expected 000010, drive 000011), then resume the correct stream (000020...) -> err_pulse high exactly 1 cycle, err_count=1, locked stays 1, following words match.
- While locked, drive 3 consecutive wrong words -> err_count=3, locked falls on the edge after the 3rd; a correct stream then relocks after 1 seed + 4 matches.
- data_valid toggled 0/1 every other cycle during a correct stream -> lock after 5 valid words regardless of gaps; word_count counts only valid cycles.
- Drive 000000 in SEARCH -> stays SEARCH, zero_word=1; it persists after a later lock and clears only on reset.
- Assert reset asynchronously mid-cycle while locked with err_count=5 -> all outputs 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/lfsr_stream_checker.sv
// Receive-side checker for a parallel LFSR state stream: self-synchronises, then
// flywheels the prediction and counts mismatches and checked words while locked.
module lfsr_stream_checker #(
  parameter int unsigned      WIDTH         = 24,
  parameter logic [WIDTH-1:0] TAP_MASK      = 24'hE10000,
  parameter int unsigned      LOCK_COUNT    = 4,
  parameter int unsigned      UNLOCK_ERRORS = 3,
  parameter int unsigned      CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_valid,
  input  logic [WIDTH-1:0] data_in,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] word_count,
  output logic             zero_word
);

  typedef enum logic [1:0] {StSearch, StVerify, StLocked} state_e;

  localparam logic [3:0]       LockCnt   = 4'(LOCK_COUNT);
  localparam logic [3:0]       UnlockCnt = 4'(UNLOCK_ERRORS);
  localparam logic [CNT_W-1:0] CntMax    = '1;

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAP_MASK)};
  endfunction

  state_e           state_q;
  logic [WIDTH-1:0] predict_q;
  logic [3:0]       run_q;
  logic [3:0]       miss_q;

  logic             data_zero;
  logic             match;
  logic [WIDTH-1:0] seed_next;
  logic [WIDTH-1:0] fly_next;
  logic [3:0]       run_inc;
  logic [3:0]       miss_inc;

  always_comb begin
    data_zero = (data_in == '0);
    match     = (data_in == predict_q);
    seed_next = lfsr_next(data_in);
    fly_next  = lfsr_next(predict_q);
    run_inc   = run_q + 4'd1;
    miss_inc  = miss_q + 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StSearch;
      predict_q  <= '0;
      run_q      <= '0;
      miss_q     <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
      word_count <= '0;
      zero_word  <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (data_valid) begin
        if (data_zero) begin
          zero_word <= 1'b1;
        end
        unique case (state_q)
          StSearch: begin
            if (!data_zero) begin
              predict_q <= seed_next;
              run_q     <= '0;
              state_q   <= StVerify;
            end
          end
          StVerify: begin
            if (match) begin
              run_q     <= run_inc;
              predict_q <= seed_next;
              if (run_inc == LockCnt) begin
                state_q <= StLocked;
                locked  <= 1'b1;
                miss_q  <= '0;
              end
            end else if (data_zero) begin
              // A zero reseed would predict zero forever; hunt for a real seed instead.
              run_q   <= '0;
              state_q <= StSearch;
            end else begin
              predict_q <= seed_next;
              run_q     <= '0;
            end
          end
          StLocked: begin
            // Flywheel: a corrupt word must not poison the prediction.
            predict_q <= fly_next;
            if (word_count != CntMax) begin
              word_count <= word_count + 1'b1;
            end
            if (match) begin
              miss_q <= '0;
            end else begin
              err_pulse <= 1'b1;
              if (err_count != CntMax) begin
                err_count <= err_count + 1'b1;
              end
              miss_q <= miss_inc;
              if (miss_inc == UnlockCnt) begin
                state_q <= StSearch;
                locked  <= 1'b0;
                miss_q  <= '0;
                run_q   <= '0;
              end
            end
          end
          default: begin
            state_q <= StSearch;
            locked  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
